// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out SPI-style transmitter, MSB first.
// Ports: clk, rst_n (async, active-low); tx_data/tx_valid/tx_ready
// byte handshake; mosi serial data; shift_en receiver enable (~cs_n);
// cs_n frame select; done one-cycle end-of-frame pulse.
// Option: define PISO_TX_HOLD_BUF_EN for a one-entry holding buffer
// that chains frames back-to-back without a DONE gap.
module piso_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              mosi,
    output logic              shift_en,
    output logic              cs_n,
    output logic              done
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] sreg, sreg_nx;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic              cs_q, cs_nx;
    logic              done_q, done_nx;
    logic              rdy_q, rdy_nx;
    logic              accept;
    logic              chain;
    logic [DATA_W-1:0] next_byte;

    assign accept = tx_valid & rdy_q;

`ifdef PISO_TX_HOLD_BUF_EN
    logic [DATA_W-1:0] buf_q, buf_nx;
    logic              full_q, full_nx;

    // Ready is never high while full, so buffer and tx_data never
    // compete for the shifter at the last-bit edge.
    assign chain     = full_q | accept;
    assign next_byte = full_q ? buf_q : tx_data;
`else
    assign chain     = 1'b0;
    assign next_byte = tx_data;
`endif

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        cs_nx      = cs_q;
        done_nx    = 1'b0;
`ifdef PISO_TX_HOLD_BUF_EN
        buf_nx     = buf_q;
        full_nx    = full_q;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx   = SHIFT;
                    sreg_nx    = tx_data;
                    bit_cnt_nx = LAST;
                    cs_nx      = 1'b0;
                end
            end
            SHIFT: begin
`ifdef PISO_TX_HOLD_BUF_EN
                if (accept) begin
                    buf_nx  = tx_data;
                    full_nx = 1'b1;
                end
`endif
                if (bit_cnt == '0) begin
                    done_nx = 1'b1;
                    if (chain) begin
                        // Next byte goes straight into the shifter.
                        sreg_nx    = next_byte;
                        bit_cnt_nx = LAST;
`ifdef PISO_TX_HOLD_BUF_EN
                        full_nx    = 1'b0;
`endif
                    end else begin
                        state_nx = DONE;
                        sreg_nx  = '0;
                        cs_nx    = 1'b1;
                    end
                end else begin
                    sreg_nx    = {sreg[DATA_W-2:0], 1'b0};
                    bit_cnt_nx = bit_cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Ready is registered from the next state so it is glitch-free.
        rdy_nx = (state_nx == IDLE);
`ifdef PISO_TX_HOLD_BUF_EN
        rdy_nx = rdy_nx | ((state_nx == SHIFT) & ~full_nx);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
            cs_q    <= cs_nx;
            done_q  <= done_nx;
            rdy_q   <= rdy_nx;
        end
    end

`ifdef PISO_TX_HOLD_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            full_q <= 1'b0;
        end else begin
            buf_q  <= buf_nx;
            full_q <= full_nx;
        end
    end
`endif

    // Shifter drains to zero, so mosi is 0 outside SHIFT.
    assign mosi     = sreg[DATA_W-1];
    assign cs_n     = cs_q;
    assign shift_en = ~cs_q;
    assign done     = done_q;
    assign tx_ready = rdy_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx framing, handshake,
// loopback, mid-frame reset and (optionally) back-to-back chaining.
module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       mosi;
    logic       shift_en;
    logic       cs_n;
    logic       done;
    logic [7:0] rx;

    int n_vec;
    int n_err;

    piso_tx #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mosi     (mosi),
        .shift_en (shift_en),
        .cs_n     (cs_n),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback receiver: shift-left, enabled by shift_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx <= '0;
        else if (shift_en) rx <= {rx[6:0], mosi};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte and return at the negedge after the accept edge.
    task automatic start(input logic [7:0] b, input bit keep);
        int t;
        tx_data  = b;
        tx_valid = 1'b1;
        t = 0;
        while (!tx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", tx_ready, 1'b1);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic expect_bits(input logic [7:0] b, input int n,
                               input int swap_at,
                               input logic [7:0] swap_val);
        for (int i = 0; i < n; i++) begin
            if (i == swap_at) tx_data = swap_val;
            chk("mosi", mosi, b[7-i]);
            chk("cs_low", cs_n, 1'b0);
            chk("sh_en", shift_en, 1'b1);
            chk("no_done", done, 1'b0);
`ifndef PISO_TX_HOLD_BUF_EN
            chk("busy", tx_ready, 1'b0);
`endif
            @(negedge clk);
        end
    endtask

    task automatic expect_done();
        chk("done", done, 1'b1);
        chk("done_cs", cs_n, 1'b1);
        chk("done_sh", shift_en, 1'b0);
        chk("done_mosi", mosi, 1'b0);
        chk("done_rdy", tx_ready, 1'b0);
        @(negedge clk);
        chk("idle_done", done, 1'b0);
        chk("idle_rdy", tx_ready, 1'b1);
        chk("idle_cs", cs_n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat [3];
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        pat[0]   = 8'h00;
        pat[1]   = 8'hFF;
        pat[2]   = 8'h3C;

        // Held reset
        repeat (2) @(negedge clk);
        chk("rst_rdy", tx_ready, 1'b0);
        chk("rst_cs", cs_n, 1'b1);
        chk("rst_sh", shift_en, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy0", tx_ready, 1'b0);
        @(negedge clk);
        chk("rel_rdy1", tx_ready, 1'b1);

        // 0xA5 frame with loopback
        start(8'hA5, 1'b0);
        expect_bits(8'hA5, 8, -1, 8'h00);
        expect_done();
        chk("rx_a5", rx, 8'hA5);

        // Loopback patterns
        for (int p = 0; p < 3; p++) begin
            start(pat[p], 1'b0);
            expect_bits(pat[p], 8, -1, 8'h00);
            expect_done();
            chk("rx_pat", rx, pat[p]);
        end

`ifndef PISO_TX_HOLD_BUF_EN
        // tx_valid held; data changes mid-frame and is only taken
        // once ready returns after the DONE cycle.
        start(8'h81, 1'b1);
        expect_bits(8'h81, 8, 3, 8'h7E);
        expect_done();
        @(negedge clk);
        tx_valid = 1'b0;
        expect_bits(8'h7E, 8, -1, 8'h00);
        expect_done();
        chk("rx_7e", rx, 8'h7E);
`else
        // Back-to-back: 0x12 then 0x34 accepted at k+2.
        begin
            logic [15:0] w;
            w = 16'h1234;
            start(8'h12, 1'b0);
            for (int i = 0; i < 16; i++) begin
                chk("b2b_mosi", mosi, w[15-i]);
                chk("b2b_cs", cs_n, 1'b0);
                chk("b2b_sh", shift_en, 1'b1);
                chk("b2b_done", done, (i == 8) ? 1'b1 : 1'b0);
                if (i == 1) begin
                    chk("b2b_rdy", tx_ready, 1'b1);
                    tx_data  = 8'h34;
                    tx_valid = 1'b1;
                end
                if (i == 2) begin
                    tx_valid = 1'b0;
                    chk("b2b_full", tx_ready, 1'b0);
                end
                @(negedge clk);
            end
            expect_done();
            chk("rx_34", rx, 8'h34);
        end
`endif

        // Mid-frame reset at k+4 of 0xF0
        start(8'hF0, 1'b0);
        expect_bits(8'hF0, 4, -1, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", cs_n, 1'b1);
        chk("abort_sh", shift_en, 1'b0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_rdy", tx_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        chk("abort_rdy0", tx_ready, 1'b0);
        @(negedge clk);
        chk("abort_rdy1", tx_ready, 1'b1);
        chk("abort_nodone2", done, 1'b0);

        // Recovery frame
        start(8'h3C, 1'b0);
        expect_bits(8'h3C, 8, -1, 8'h00);
        expect_done();
        chk("rx_rec", rx, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
